rv32i_imem_loader: RTL and testbench

Instruction-memory writer for the RV32I pipeline: receives a framed byte stream (from a UART receiver or a debug bridge) and writes the program into the write port of the instruction RAM. The pipeline's fetch stage reads that RAM. While a frame is in progress the block asserts `cpu_hold`, which keeps the pipeline in reset. On a valid frame it releases the pipeline. On a malformed frame it reports an error and keeps the pipeline held.

---
 rtl/rv32i_imem_loader_pkg.sv | 17 +
 rtl/rv32i_imem_loader.sv | 163 ++++++++++++++++
 tb/tb_rv32i_imem_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package rv32i_loaderPkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam logic [7:0]  LOADER_MAGIC  = 8'hA5;
  localparam int unsigned LOADER_CSUM_W = 8;

endpackage

// File: rtl/rv32i_imem_loader.sv
// Framed byte-stream loader that writes a program into instruction RAM and
// holds the pipeline in reset until a frame with a good checksum completes.
module rv32i_imem_loader
  import rv32i_loaderPkg::*;
#(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [29:0] w_addr,
  output logic [31:0] w_data,
  output logic        w_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = 16;

  loader_state_t              state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [23:0]                word_q, word_d;
  logic [1:0]                 lane_q, lane_d;
  logic [LOADER_CSUM_W-1:0]   csum_q, csum_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [29:0]                w_addr_d;
  logic [31:0]                w_data_d;
  logic                       w_en_d, hold_d, done_d, err_d, rx_ready_d;
  logic                       accept_c, timing_c;
  logic [IDX_W-1:0]           count_c;

  assign accept_c = rx_valid && rx_ready;
  assign timing_c = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign count_c  = {rx_data, cnt_q[7:0]};

  // State and output registers; reset drops any partial word silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      lane_q     <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      rx_ready   <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      w_en       <= 1'b0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      rx_ready   <= rx_ready_d;
      w_addr     <= w_addr_d;
      w_data     <= w_data_d;
      w_en       <= w_en_d;
      cpu_hold   <= hold_d;
      load_done  <= done_d;
      load_error <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    lane_d     = lane_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    rx_ready_d = 1'b1;
    w_addr_d   = w_addr;
    w_data_d   = w_data;
    w_en_d     = 1'b0;
    hold_d     = cpu_hold;
    done_d     = load_done;
    err_d      = load_error;

    if (timing_c) begin
      tmo_d = accept_c ? '0 : tmo_q + TMO_W'(1);
    end

    if (timing_c && (tmo_q == TMO_W'(TIMEOUT_CYCLES))) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
      tmo_d   = '0;
    end else if (accept_c) begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (rx_data == LOADER_MAGIC) begin
            state_d = ST_CNT_LO;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
            lane_d  = '0;
            csum_d  = '0;
            tmo_d   = '0;
          end
        end
        ST_CNT_LO: begin
          cnt_d   = {8'h00, rx_data};
          state_d = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_d = count_c;
          if (32'(count_c) > MEM_WORDS) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else if (count_c == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          // Bytes arrive LSB first, so shift in from the top.
          csum_d = csum_q + rx_data;
          word_d = {rx_data, word_q[23:8]};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            w_en_d   = 1'b1;
            w_addr_d = 30'(idx_q);
            w_data_d = {rx_data, word_q};
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == cnt_q - IDX_W'(1)) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Directed bench for rv32i_imem_loader with MEM_WORDS=4, TIMEOUT_CYCLES=16.
module tb_rv32i_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [29:0] w_addr;
  logic [31:0] w_data;
  logic        w_en;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int vectors     = 0;
  int miscompares = 0;

  logic [29:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  fr[$];
  int          base;

  rv32i_imem_loader #(.MEM_WORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_en       (w_en),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  // Log every write strobe, one entry per high cycle.
  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wa.push_back(w_addr);
      wd.push_back(w_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    foreach (fr[i]) send_byte(fr[i]);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic h);
    check({tag, ".done"},  32'(load_done),  32'(d));
    check({tag, ".error"}, 32'(load_error), 32'(e));
    check({tag, ".hold"},  32'(cpu_hold),   32'(h));
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rx_ready", 32'(rx_ready), 32'd0);
    check("rst.w_en",     32'(w_en),     32'd0);
    check("rst.w_addr",   32'(w_addr),   32'd0);
    check("rst.w_data",   w_data,        32'd0);
    status("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    check("rel.rx_ready", 32'(rx_ready), 32'd1);

    // Basic two-word load with latency checks on the first write
    base = wa.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    foreach (fr[i]) begin
      send_byte(fr[i]);
      if (i == 0) check("basic.hold_rise", 32'(cpu_hold), 32'd1);
      if (i == 6) begin
        check("basic.w_en_lat", 32'(w_en),   32'd1);
        check("basic.w_addr0",  32'(w_addr), 32'd0);
        check("basic.w_data0",  w_data,      32'h0000_0013);
      end
      if (i == 7) check("basic.w_en_pulse", 32'(w_en), 32'd0);
    end
    rx_valid = 1'b0;
    status("basic", 1'b1, 1'b0, 1'b0);
    check("basic.w_addr_hold", 32'(w_addr), 32'd1);
    check("basic.w_data_hold", w_data,      32'h0010_0093);
    idle(2);
    check("basic.nwrites", 32'(wa.size() - base), 32'd2);
    check("basic.wd1",     wd[base + 1],          32'h0010_0093);

    // Bad checksum: writes still land, frame reports error
    base = wa.size();
    fr[11] = 8'hB7;
    send_frame();
    status("badcs", 1'b0, 1'b1, 1'b1);
    idle(2);
    check("badcs.nwrites", 32'(wa.size() - base), 32'd2);

    // Count at the MEM_WORDS bound
    base = wa.size();
    fr = '{8'hA5, 8'h04, 8'h00};
    for (int k = 1; k <= 16; k++) fr.push_back(8'(k));
    fr.push_back(8'h88);
    send_frame();
    status("bound", 1'b1, 1'b0, 1'b0);
    idle(2);
    check("bound.nwrites", 32'(wa.size() - base), 32'd4);
    check("bound.wa3",     32'(wa[base + 3]),     32'd3);
    check("bound.wd3",     wd[base + 3],          32'h100F_0E0D);
    check("bound.wd0",     wd[base],              32'h0403_0201);

    // Count one above the bound errors after the high count byte
    base = wa.size();
    fr = '{8'hA5, 8'h05, 8'h00};
    send_frame();
    status("over", 1'b0, 1'b1, 1'b1);
    idle(4);
    check("over.nwrites", 32'(wa.size() - base), 32'd0);

    // Noise then zero-length frame
    base = wa.size();
    fr = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    status("zero", 1'b1, 1'b0, 1'b0);
    idle(2);
    check("zero.nwrites", 32'(wa.size() - base), 32'd0);

    // Timeout mid-word: error lands 17 cycles after the last handshake
    base = wa.size();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
    send_frame();
    idle(16);
    check("tmo.early", 32'(load_error), 32'd0);
    idle(1);
    status("tmo", 1'b0, 1'b1, 1'b1);
    idle(2);
    check("tmo.nwrites", 32'(wa.size() - base), 32'd0);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame();
    status("recover", 1'b1, 1'b0, 1'b0);

    // Reset after the second data byte
    base = wa.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_frame();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.rx_ready", 32'(rx_ready), 32'd0);
    check("midrst.w_en",     32'(w_en),     32'd0);
    check("midrst.w_addr",   32'(w_addr),   32'd0);
    check("midrst.w_data",   w_data,        32'd0);
    status("midrst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(1);
    check("midrst.nwrites", 32'(wa.size() - base), 32'd0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    send_frame();
    status("postrst", 1'b1, 1'b0, 1'b0);
    idle(2);
    check("postrst.nwrites", 32'(wa.size() - base), 32'd1);
    check("postrst.wa0",     32'(wa[base]),         32'd0);
    check("postrst.wd0",     wd[base],              32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
